// File: rtl/tt4_checker_if.sv
// Stimulus/response and status bundle between tt4_checker and the circuit under test.
// master is the checker side; slave is the lab-circuit/observer side.
`timescale 1ns/1ps
interface tt4_checker_if;
  logic       start;
  logic       x1, x2, x3, x4;
  logic       f, g, h;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       err_valid;
  logic [3:0] first_err_idx;
  logic [2:0] first_err_val;

  modport master (
    input  start, f, g, h,
    output x1, x2, x3, x4, busy, done, pass,
           err_count, err_valid, first_err_idx, first_err_val
  );

  modport slave (
    output start, f, g, h,
    input  x1, x2, x3, x4, busy, done, pass,
           err_count, err_valid, first_err_idx, first_err_val
  );
endinterface

// File: rtl/tt4_checker.sv
// Exhaustive 16-vector sweep of a 4-in/3-out combinational circuit against a
// golden truth table, reporting mismatch count, first failure and pass flag.
`timescale 1ns/1ps
module tt4_checker #(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [15:0] EXP_F       = 16'h0000,
  parameter logic [15:0] EXP_G       = 16'h0000,
  parameter logic [15:0] EXP_H       = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  tt4_checker_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] err_count_q, err_count_d;
  logic       err_valid_q, err_valid_d;
  logic [3:0] first_err_idx_q, first_err_idx_d;
  logic [2:0] first_err_val_q, first_err_val_d;

  logic [2:0] obs;
  logic [2:0] exp_val;
  logic       mismatch;

  assign obs      = {bus.f, bus.g, bus.h};
  assign exp_val  = {EXP_F[idx_q], EXP_G[idx_q], EXP_H[idx_q]};
  assign mismatch = (obs != exp_val);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    pass_d          = pass_q;
    err_count_d     = err_count_q;
    err_valid_d     = err_valid_q;
    first_err_idx_d = first_err_idx_q;
    first_err_val_d = first_err_val_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d         = S_SETTLE;
          idx_d           = '0;
          cnt_d           = '0;
          busy_d          = 1'b1;
          pass_d          = 1'b0;
          err_count_d     = '0;
          err_valid_d     = 1'b0;
          first_err_idx_d = '0;
          first_err_val_d = '0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == HOLD_LAST) state_d = S_SAMPLE;
        else                    cnt_d   = cnt_q + 8'd1;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          err_count_d = err_count_q + 5'd1;
          if (!err_valid_q) begin
            err_valid_d     = 1'b1;
            first_err_idx_d = idx_q;
            first_err_val_d = obs;
          end
        end
        if (idx_q == 4'd15) begin
          // pass is taken from the updated count so the final vector is included
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_count_d == 5'd0);
        end else begin
          state_d = S_SETTLE;
          idx_d   = idx_q + 4'd1;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_count_q     <= '0;
      err_valid_q     <= 1'b0;
      first_err_idx_q <= '0;
      first_err_val_q <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_count_q     <= err_count_d;
      err_valid_q     <= err_valid_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_val_q <= first_err_val_d;
    end
  end

  assign bus.x1            = idx_q[3];
  assign bus.x2            = idx_q[2];
  assign bus.x3            = idx_q[1];
  assign bus.x4            = idx_q[0];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_count_q;
  assign bus.err_valid     = err_valid_q;
  assign bus.first_err_idx = first_err_idx_q;
  assign bus.first_err_val = first_err_val_q;

endmodule

// File: tb/tb_tt4_checker.sv
// Directed bench for tt4_checker: lab model f=x1^x2, g=x3&x4, h=x1|x4 with
// injectable faults, run against HOLD_CYCLES=4 and HOLD_CYCLES=1 instances.
`timescale 1ns/1ps
module tb_tt4_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   fault = 0;   // 0: correct, 1: g stuck at 0, 2: f inverted
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  tt4_checker_if bus_a ();
  tt4_checker_if bus_b ();

  assign bus_a.f = (bus_a.x1 ^ bus_a.x2) ^ (fault == 2);
  assign bus_a.g = (fault == 1) ? 1'b0 : (bus_a.x3 & bus_a.x4);
  assign bus_a.h = bus_a.x1 | bus_a.x4;

  assign bus_b.f = bus_b.x1 ^ bus_b.x2;
  assign bus_b.g = bus_b.x3 & bus_b.x4;
  assign bus_b.h = bus_b.x1 | bus_b.x4;

  tt4_checker #(
    .HOLD_CYCLES(4),
    .EXP_F(16'h0FF0),
    .EXP_G(16'h8888),
    .EXP_H(16'hFFAA)
  ) u_dut_a (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_a)
  );

  tt4_checker #(
    .HOLD_CYCLES(1),
    .EXP_F(16'h0FF0),
    .EXP_G(16'h8888),
    .EXP_H(16'hFFAA)
  ) u_dut_b (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [3:0] cur_x(input int inst);
    return inst != 0 ? {bus_b.x1, bus_b.x2, bus_b.x3, bus_b.x4}
                     : {bus_a.x1, bus_a.x2, bus_a.x3, bus_a.x4};
  endfunction

  function automatic logic cur_done(input int inst);
    return inst != 0 ? bus_b.done : bus_a.done;
  endfunction

  function automatic logic cur_busy(input int inst);
    return inst != 0 ? bus_b.busy : bus_a.busy;
  endfunction

  function automatic logic [12:0] cur_err(input int inst);
    return inst != 0 ? {bus_b.err_count, bus_b.err_valid, bus_b.first_err_idx, bus_b.first_err_val}
                     : {bus_a.err_count, bus_a.err_valid, bus_a.first_err_idx, bus_a.first_err_val};
  endfunction

  // {x1..x4, busy, done, pass, err_count, err_valid, first_err_idx, first_err_val}
  function automatic logic [19:0] outs_a();
    return {bus_a.x1, bus_a.x2, bus_a.x3, bus_a.x4, bus_a.busy, bus_a.done, bus_a.pass,
            bus_a.err_count, bus_a.err_valid, bus_a.first_err_idx, bus_a.first_err_val};
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst != 0) bus_b.start = v;
    else           bus_a.start = v;
  endtask

  // One start pulse, then follow the sweep at negedges until done (bounded).
  // lat = cycles from the start-taking edge to the cycle where done is seen.
  task automatic sweep(input int inst, input int hold, input int repulse_k,
                       output int lat, output bit seq_ok, output logic [12:0] err0);
    lat    = -1;
    seq_ok = 1'b1;
    err0   = '1;
    @(negedge clk) set_start(inst, 1'b1);
    @(negedge clk) set_start(inst, 1'b0);
    for (int k = 0; k < 400; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) err0 = cur_err(inst);
      if (k == repulse_k)     set_start(inst, 1'b1);
      if (k == repulse_k + 1) set_start(inst, 1'b0);
      if (cur_done(inst)) begin
        lat = k + 1;
        break;
      end
      if (cur_x(inst) !== 4'(k / (hold + 1)) || cur_busy(inst) !== 1'b1) seq_ok = 1'b0;
    end
  endtask

  int          lat;
  bit          seq_ok;
  logic [12:0] err0;

  initial begin
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_outs_a", 32'(outs_a()), 32'h0);
    check("reset_err_b", 32'(cur_err(1)), 32'h0);
    rst_n = 1'b1;

    // Correct model, single start
    sweep(0, 4, -10, lat, seq_ok, err0);
    check("ok_latency", 32'(lat), 32'd81);
    check("ok_x_sequence", 32'(seq_ok), 32'd1);
    check("ok_pass", 32'(bus_a.pass), 32'd1);
    check("ok_err", 32'(cur_err(0)), 32'h0);
    @(negedge clk);
    check("ok_done_one_cycle", 32'({bus_a.done, bus_a.busy, bus_a.pass}), 32'b001);

    // g stuck at 0
    fault = 1;
    sweep(0, 4, -10, lat, seq_ok, err0);
    check("gstuck_latency", 32'(lat), 32'd81);
    check("gstuck_err_count", 32'(bus_a.err_count), 32'd4);
    check("gstuck_err_valid", 32'(bus_a.err_valid), 32'd1);
    check("gstuck_first_idx", 32'(bus_a.first_err_idx), 32'd3);
    check("gstuck_first_val", 32'(bus_a.first_err_val), 32'b001);
    check("gstuck_pass", 32'(bus_a.pass), 32'd0);

    // f inverted, with an ignored start re-pulse at cycle 20
    fault = 2;
    sweep(0, 4, 20, lat, seq_ok, err0);
    check("finv_cleared_on_start", 32'(err0), 32'h0);
    check("finv_latency_no_restart", 32'(lat), 32'd81);
    check("finv_x_sequence", 32'(seq_ok), 32'd1);
    check("finv_err_count", 32'(bus_a.err_count), 32'd16);
    check("finv_first_idx", 32'(bus_a.first_err_idx), 32'd0);
    check("finv_first_val", 32'(bus_a.first_err_val), 32'b100);
    check("finv_pass", 32'(bus_a.pass), 32'd0);
    repeat (3) @(negedge clk);
    check("finv_results_persist", 32'({bus_a.err_count, bus_a.err_valid, bus_a.busy}), 32'({5'd16, 1'b1, 1'b0}));

    // Reset mid-sweep while idx=7
    fault = 0;
    @(negedge clk) set_start(0, 1'b1);
    @(negedge clk) set_start(0, 1'b0);
    repeat (37) @(negedge clk);
    check("rst_pre_idx7", 32'(cur_x(0)), 32'd7);
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", 32'(outs_a()), 32'h0);
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus_a.done !== 1'b0 || bus_a.busy !== 1'b0) lat = 1;
    end
    check("rst_no_done", 32'(lat), 32'd0);
    rst_n = 1'b1;
    sweep(0, 4, -10, lat, seq_ok, err0);
    check("post_rst_latency", 32'(lat), 32'd81);
    check("post_rst_pass", 32'(bus_a.pass), 32'd1);

    // HOLD_CYCLES=1 instance
    sweep(1, 1, -10, lat, seq_ok, err0);
    check("h1_latency", 32'(lat), 32'd33);
    check("h1_x_sequence", 32'(seq_ok), 32'd1);
    check("h1_pass", 32'(bus_b.pass), 32'd1);
    check("h1_err", 32'(cur_err(1)), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
